uart_rx: RTL and testbench

//   Serial UART receiver, 8N1, LSB first. Downstream consumer of the uart_tx serial line.

---
 rtl/uart_rx.sv | 65 ++++++
 tb/tb_uart_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with 2-FF input sync, mid-bit sampling and stop-bit framing check
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_next;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic tick, mid, good, bad;
  assign tick = cnt == LAST;
  assign mid = cnt == MID;
  assign good = state == STOP && tick && rx_s;
  assign bad = state == STOP && tick && !rx_s;
  assign busy = state != IDLE;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = rx_s ? IDLE : START;
      START:     state_next = mid ? (rx_s ? IDLE : DATA) : START;
      DATA:      state_next = tick && bit_idx == 3'd7 ? STOP : DATA;
      STOP:      state_next = tick ? (rx_s ? IDLE : WAIT_HIGH) : STOP;
      WAIT_HIGH: state_next = rx_s ? IDLE : WAIT_HIGH;
      default:   state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      state <= state_next;
      cnt <= state_next != state || tick ? '0 : cnt + 1'b1;
      data_valid <= good;
      frame_err <= bad;
      if (state == START) bit_idx <= '0;
      if (state == DATA && tick) begin
        shift[bit_idx] <= rx_s;
        bit_idx <= bit_idx + 1'b1;
      end
      if (good) data_out <= shift;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard-driven bench for uart_rx using a bit-banged serial transmitter
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [7:0] data_out;
  logic data_valid, frame_err, busy;
  int asserts = 0;
  int fails = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int fall_cyc = 0;
  int last_dv_cyc = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        asserts++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: data_out=%h with no frame pending", data_out);
        end else begin
          exp_b = exp_q.pop_front();
          if (data_out !== exp_b) begin
            fails++;
            $display("FAIL sb_data: data_out=%h expected=%h", data_out, exp_b);
          end
        end
      end
      if (frame_err) fe_cnt++;
      if (data_valid || frame_err) begin
        asserts++;
        if ((data_valid && frame_err) || prev_strobe) begin
          fails++;
          $display("FAIL strobe_shape: dv=%b fe=%b prev=%b expected single exclusive pulse", data_valid, frame_err, prev_strobe);
        end
      end
      prev_strobe = data_valid | frame_err;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    fall_cyc = cyc;
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop;
    cycles(CPB);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 20 * CPB) begin
      cycles(1);
      n++;
    end
    asserts++;
    if (n >= 20 * CPB) begin
      fails++;
      $display("FAIL %s_timeout: pending=%0d busy=%b expected drained and idle", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx = 1'b1;
    cycles(5);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      asserts++;
      if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle: cycle %0d data_out=%h dv=%b fe=%b busy=%b expected 00/0/0/0", i, data_out, data_valid, frame_err, busy);
      end
    end
  endtask

  task automatic test_loopback;
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_done("loopback");
    cycles(CPB);
    asserts++;
    if (dv_cnt - dv0 !== 1 || fe_cnt - fe0 !== 0 || data_out !== 8'hA5) begin
      fails++;
      $display("FAIL loopback: dv=%0d fe=%0d data_out=%h expected 1/0/a5", dv_cnt - dv0, fe_cnt - fe0, data_out);
    end
    asserts++;
    if (last_dv_cyc - fall_cyc < 3 + CPB / 2 + 9 * CPB - 1 || last_dv_cyc - fall_cyc > 3 + CPB / 2 + 9 * CPB + 1) begin
      fails++;
      $display("FAIL loopback_latency: %0d cycles expected %0d +/-1", last_dv_cyc - fall_cyc, 3 + CPB / 2 + 9 * CPB);
    end
  endtask

  task automatic test_back_to_back;
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    wait_done("back_to_back");
    cycles(CPB);
    asserts++;
    if (dv_cnt - dv0 !== 2 || fe_cnt - fe0 !== 0 || data_out !== 8'hFF) begin
      fails++;
      $display("FAIL back_to_back: dv=%0d fe=%0d data_out=%h expected 2/0/ff", dv_cnt - dv0, fe_cnt - fe0, data_out);
    end
  endtask

  task automatic test_glitch;
    int dv0, fe0, t_hi, t_lo;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    t_hi = -1;
    t_lo = -1;
    rx = 1'b0;
    for (int i = 1; i <= 3 * CPB; i++) begin
      cycles(1);
      if (i == CPB / 4) rx = 1'b1;
      if (busy && t_hi < 0) t_hi = i;
      if (!busy && t_hi >= 0 && t_lo < 0) t_lo = i;
    end
    asserts++;
    if (t_hi < 0 || t_lo < 0 || t_lo > 3 + CPB / 2 + 2) begin
      fails++;
      $display("FAIL glitch_busy: rise=%0d fall=%0d expected pulse ending by %0d", t_hi, t_lo, 3 + CPB / 2 + 2);
    end
    asserts++;
    if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_strobe: dv=%0d fe=%0d busy=%b expected 0/0/0", dv_cnt - dv0, fe_cnt - fe0, busy);
    end
  endtask

  task automatic test_frame_err;
    int dv0, fe0, n;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    cycles(3 * CPB);
    asserts++;
    if (fe_cnt - fe0 !== 1 || dv_cnt - dv0 !== 0 || data_out !== 8'hFF || busy !== 1'b1) begin
      fails++;
      $display("FAIL frame_err: fe=%0d dv=%0d data_out=%h busy=%b expected 1/0/ff/1", fe_cnt - fe0, dv_cnt - dv0, data_out, busy);
    end
    rx = 1'b1;
    cycles(1);
    asserts++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL frame_err_hold: busy=%b expected 1 before rx_s high", busy);
    end
    n = 0;
    while (busy && n < 5) begin
      cycles(1);
      n++;
    end
    asserts++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_err_release: busy=%b expected 0", busy);
    end
    cycles(CPB);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    wait_done("after_ferr");
    asserts++;
    if (data_out !== 8'hC3 || fe_cnt - fe0 !== 1) begin
      fails++;
      $display("FAIL after_ferr: data_out=%h fe=%0d expected c3/1", data_out, fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int dv0, fe0;
    logic [7:0] b;
    b = 8'h81;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = b[4];
    cycles(CPB / 2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    rx = 1'b1;
    asserts++;
    if (busy !== 1'b0 || data_out !== 8'h00 || data_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b data_out=%h dv=%b expected 0/00/0", busy, data_out, data_valid);
    end
    cycles(2 * CPB);
    asserts++;
    if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_quiet: dv=%0d fe=%0d busy=%b expected 0/0/0", dv_cnt - dv0, fe_cnt - fe0, busy);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_done("mid_reset_next");
    asserts++;
    if (data_out !== 8'h5A || dv_cnt - dv0 !== 1) begin
      fails++;
      $display("FAIL mid_reset_next: data_out=%h dv=%0d expected 5a/1", data_out, dv_cnt - dv0);
    end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid_frame;
    cycles(4);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
